mem_io_stage: RTL

- MEM stage of the 5-stage MIPS pipeline; consumes the EX/MEM pipeline register outputs (address, store data, MEM and WB control, IO flag).
- Performs the data-memory access, or runs an IO-bus transaction with a 4-phase req/ack handshake and a timeout.
- Generates branch select, pipeline stall and misalignment exception.
- Holds the MEM/WB pipeline register feeding writeback.

---
 rtl/mem_io_stage_pkg.sv | 25 ++
 rtl/mem_io_dmem.sv | 23 ++
 rtl/mem_io_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_io_stage_pkg.sv
// Shared MEM-stage definitions: control-bus bit positions, IO FSM encoding
// and the alignment helper used by the MEM stage.
package mem_io_stage_pkg;

  localparam int unsigned MEM_RD = 0;
  localparam int unsigned MEM_WR = 1;
  localparam int unsigned MEM_BR = 2;

  localparam int unsigned WB_MEM2REG = 0;
  localparam int unsigned WB_REGWR   = 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } io_state_e;

  // A load or store whose byte offset is not word aligned.
  function automatic logic is_misaligned(input logic [3:0] mem_ctrl,
                                         input logic [1:0] byte_off);
    return (mem_ctrl[MEM_RD] | mem_ctrl[MEM_WR]) & (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_io_dmem.sv
// Word-addressed data memory: combinational read, write on rising edge.
// Contents are deliberately not reset.
module mem_io_dmem #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_io_stage.sv
// MIPS MEM stage: dmem access or 4-phase IO-bus transaction with timeout,
// branch select, stall/exception generation and the MEM/WB register.
module mem_io_stage
  import mem_io_stage_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH  = 256,
  parameter int unsigned IO_TIMEOUT  = 64,
  parameter logic [31:0] IO_ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCPlus4PlusOffReg,
  input  logic        EqualReg,
  input  logic [31:0] ResultReg,
  input  logic [31:0] OutBReg,
  input  logic [4:0]  WrRegReg,
  input  logic [1:0]  WBReg,
  input  logic [3:0]  MEMReg,
  input  logic        IOInstReg,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic        mem_stall,
  output logic        mem_excep,
  output logic        io_req,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic        io_ack,
  input  logic [31:0] io_rdata,
  output logic        io_err,
  output logic [31:0] ReadDataWB,
  output logic [31:0] ResultWB,
  output logic [4:0]  WrRegWB,
  output logic [1:0]  WBWB
);

  localparam int unsigned     AW       = $clog2(DMEM_DEPTH);
  localparam int unsigned     CW       = $clog2(IO_TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(IO_TIMEOUT - 1);

  io_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic        io_req_q;
  logic        io_we_q;
  logic [31:0] io_addr_q;
  logic [31:0] io_wdata_q;
  logic        io_err_q;
  logic [31:0] io_cap_q;
  logic        excep_q;

  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  wr_reg_q, wr_reg_d;
  logic [1:0]  wb_q, wb_d;

  logic        access;
  logic        misaligned;
  logic        aligned_acc;
  logic        io_start;
  logic        dmem_we;
  logic        timeout;
  logic [31:0] dmem_rdata;
  logic        unused_mem_rsvd;

  assign unused_mem_rsvd = MEMReg[3];

  assign access      = MEMReg[MEM_RD] | MEMReg[MEM_WR];
  assign misaligned  = is_misaligned(MEMReg, ResultReg[1:0]);
  assign aligned_acc = access & ~misaligned;
  assign io_start    = (state_q == S_IDLE) & aligned_acc & IOInstReg;
  assign dmem_we     = (state_q == S_IDLE) & aligned_acc & ~IOInstReg & MEMReg[MEM_WR];
  assign timeout     = (cnt_q == CNT_LAST);

  assign PCSrc        = MEMReg[MEM_BR] & EqualReg;
  assign BranchTarget = PCPlus4PlusOffReg;
  // DONE does not stall: upstream advances on the edge that commits the IO result.
  assign mem_stall    = io_start | (state_q == S_REQ) | (state_q == S_RELEASE);

  mem_io_dmem #(
    .DEPTH (DMEM_DEPTH)
  ) u_dmem (
    .clk     (clk),
    .we_i    (dmem_we),
    .addr_i  (ResultReg[AW+1:2]),
    .wdata_i (OutBReg),
    .rdata_o (dmem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      io_req_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
      io_err_q   <= 1'b0;
      io_cap_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (io_start) begin
            state_q    <= S_REQ;
            cnt_q      <= '0;
            io_req_q   <= 1'b1;
            io_we_q    <= MEMReg[MEM_WR];
            io_addr_q  <= ResultReg;
            io_wdata_q <= OutBReg;
          end
        end
        S_REQ: begin
          if (io_ack) begin
            io_cap_q <= io_rdata;
            io_req_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_RELEASE;
          end else if (timeout) begin
            io_cap_q <= IO_ERR_DATA;
            io_req_q <= 1'b0;
            io_err_q <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!io_ack) begin
            state_q <= S_DONE;
          end else if (timeout) begin
            io_cap_q <= IO_ERR_DATA;
            io_err_q <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // MEM/WB boundary: a stalled or faulting instruction leaves a bubble behind.
  always_comb begin
    rd_data_d = '0;
    result_d  = ResultReg;
    wr_reg_d  = WrRegReg;
    wb_d      = WBReg;
    if (mem_stall || misaligned) begin
      wb_d = '0;
    end else if (state_q == S_DONE) begin
      rd_data_d = io_cap_q;
    end else if (access) begin
      rd_data_d = dmem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
      result_q  <= '0;
      wr_reg_q  <= '0;
      wb_q      <= '0;
      excep_q   <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      result_q  <= result_d;
      wr_reg_q  <= wr_reg_d;
      wb_q      <= wb_d;
      excep_q   <= misaligned & (state_q == S_IDLE);
    end
  end

  assign mem_excep  = excep_q;
  assign io_req     = io_req_q;
  assign io_we      = io_we_q;
  assign io_addr    = io_addr_q;
  assign io_wdata   = io_wdata_q;
  assign io_err     = io_err_q;
  assign ReadDataWB = rd_data_q;
  assign ResultWB   = result_q;
  assign WrRegWB    = wr_reg_q;
  assign WBWB       = wb_q;

endmodule
